// File: rtl/seq_mult_acc_if.sv
// Handshake, operand and HI/LO result bundle for the iterative multiplier.
// The master side issues operations and HI/LO writes; the slave side is the multiplier.
interface seq_mult_acc_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] multiplicand;
    logic [WIDTH-1:0] multiplier;
    logic             wr_hi;
    logic             wr_lo;
    logic [WIDTH-1:0] wr_data;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] productHI;
    logic [WIDTH-1:0] productLO;

    modport master (
        output start, op, multiplicand, multiplier, wr_hi, wr_lo, wr_data,
        input  busy, done, productHI, productLO
    );

    modport slave (
        input  start, op, multiplicand, multiplier, wr_hi, wr_lo, wr_data,
        output busy, done, productHI, productLO
    );
endinterface

// File: rtl/seq_mult_acc.sv
// Iterative shift-add multiplier with HI/LO result registers.
// Signed ops multiply magnitudes and re-apply the sign; MADD/MSUB fold into HI:LO.
module seq_mult_acc #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input logic          clk,
    input logic          reset_n,
    seq_mult_acc_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_ITER = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MADD  = 2'b10;
    localparam logic [1:0] OP_MSUB  = 2'b11;

    logic [1:0]         state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               neg_q, neg_d;
    logic [2*WIDTH-1:0] part_q, part_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] p;
    logic [2*WIDTH-1:0] acc;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        neg_d   = neg_q;
        part_d  = part_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        // B is consumed LSB-first by shifting, so bit 0 always selects the add.
        addend = b_q[0] ? a_q : '0;
        sum    = {1'b0, part_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        p      = neg_q ? -part_q : part_q;
        acc    = {hi_q, lo_q};

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d    = bus.op;
                    a_d     = bus.multiplicand;
                    b_d     = bus.multiplier;
                    busy_d  = 1'b1;
                    state_d = S_LOAD;
                end else begin
                    if (bus.wr_hi) hi_d = bus.wr_data;
                    if (bus.wr_lo) lo_d = bus.wr_data;
                end
            end
            S_LOAD: begin
                neg_d = 1'b0;
                if (op_q != OP_MULTU) begin
                    neg_d = a_q[WIDTH-1] ^ b_q[WIDTH-1];
                    if (a_q[WIDTH-1]) a_d = -a_q;
                    if (b_q[WIDTH-1]) b_d = -b_q;
                end
                part_d  = '0;
                cnt_d   = '0;
                state_d = S_ITER;
            end
            S_ITER: begin
                part_d = {sum, part_q[WIDTH-1:1]};
                b_d    = b_q >> 1;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
            end
            default: begin
                case (op_q)
                    OP_MADD: {hi_d, lo_d} = acc + p;
                    OP_MSUB: {hi_d, lo_d} = acc - p;
                    default: {hi_d, lo_d} = p;
                endcase
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            neg_q   <= 1'b0;
            part_q  <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            neg_q   <= neg_d;
            part_q  <= part_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.productHI = hi_q;
    assign bus.productLO = lo_q;
endmodule

// File: tb/tb_seq_mult_acc.sv
// Scoreboard bench for seq_mult_acc at WIDTH=32 and WIDTH=8.
// Drivers push expected HI/LO and done edge; monitors pop and compare on each done.
module tb_seq_mult_acc;
    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          due;
    } exp_t;

    logic clk;
    logic rst_n32;
    logic rst_n8;
    int   edges  = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q32[$];
    exp_t q8[$];

    seq_mult_acc_if #(.WIDTH(32)) b32 ();
    seq_mult_acc_if #(.WIDTH(8))  b8 ();

    seq_mult_acc #(.WIDTH(32), .CNT_W(6)) dut32 (
        .clk     (clk),
        .reset_n (rst_n32),
        .bus     (b32)
    );

    seq_mult_acc #(.WIDTH(8), .CNT_W(4)) dut8 (
        .clk     (clk),
        .reset_n (rst_n8),
        .bus     (b8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) edges <= edges + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitors
    always @(negedge clk) begin
        if (b32.done === 1'b1) begin
            if (q32.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL w32_unexpected_done: got done at edge %0d expected none", edges);
            end else begin
                exp_t e;
                e = q32.pop_front();
                chk("w32_hi", b32.productHI, e.hi);
                chk("w32_lo", b32.productLO, e.lo);
                chk("w32_done_edge", 32'(edges), 32'(e.due));
            end
        end
    end

    always @(negedge clk) begin
        if (b8.done === 1'b1) begin
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL w8_unexpected_done: got done at edge %0d expected none", edges);
            end else begin
                exp_t e;
                e = q8.pop_front();
                chk("w8_hi", {24'h0, b8.productHI}, e.hi);
                chk("w8_lo", {24'h0, b8.productLO}, e.lo);
                chk("w8_done_edge", 32'(edges), 32'(e.due));
            end
        end
    end

    // Drivers: called at a negedge; return at the negedge after the start edge.
    task automatic issue32(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eh, input logic [31:0] el, input bit exp_done);
        b32.start        = 1'b1;
        b32.op           = o;
        b32.multiplicand = a;
        b32.multiplier   = b;
        @(negedge clk);
        b32.start = 1'b0;
        if (exp_done) q32.push_back('{hi: eh, lo: el, due: edges + 34});
    endtask

    task automatic issue8(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] eh, input logic [7:0] el);
        b8.start        = 1'b1;
        b8.op           = o;
        b8.multiplicand = a;
        b8.multiplier   = b;
        @(negedge clk);
        b8.start = 1'b0;
        q8.push_back('{hi: {24'h0, eh}, lo: {24'h0, el}, due: edges + 10});
    endtask

    task automatic wait_done32();
        bit seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (b32.done === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL w32_timeout: got no done within 60 cycles expected done");
        end
    endtask

    task automatic wait_done8();
        bit seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (b8.done === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL w8_timeout: got no done within 30 cycles expected done");
        end
    endtask

    task automatic run32();
        rst_n32 = 1'b0;
        repeat (2) @(negedge clk);
        chk("w32_rst_busy", {31'h0, b32.busy}, 32'h0);
        chk("w32_rst_done", {31'h0, b32.done}, 32'h0);
        chk("w32_rst_hi", b32.productHI, 32'h0);
        chk("w32_rst_lo", b32.productLO, 32'h0);
        rst_n32 = 1'b1;
        @(negedge clk);

        // Direct writes, then a signed op killed by reset mid-flight
        b32.wr_hi = 1'b1; b32.wr_lo = 1'b1; b32.wr_data = 32'h55;
        @(negedge clk);
        b32.wr_hi = 1'b0; b32.wr_lo = 1'b0;
        chk("w32_wr_hi", b32.productHI, 32'h55);
        chk("w32_wr_lo", b32.productLO, 32'h55);
        issue32(2'b01, 32'd7, 32'd9, 32'h0, 32'h0, 1'b0);
        repeat (9) @(negedge clk);
        @(posedge clk);
        rst_n32 = 1'b0;
        #1;
        chk("w32_midrst_busy", {31'h0, b32.busy}, 32'h0);
        chk("w32_midrst_hi", b32.productHI, 32'h0);
        chk("w32_midrst_lo", b32.productLO, 32'h0);
        @(negedge clk);
        rst_n32 = 1'b1;
        repeat (40) @(negedge clk);
        issue32(2'b00, 32'd2, 32'd3, 32'h0, 32'h6, 1'b1);
        wait_done32();

        // MULTU / MULT
        issue32(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b1);
        wait_done32();
        issue32(2'b00, 32'h0, 32'h12345678, 32'h0, 32'h0, 1'b1);
        wait_done32();
        issue32(2'b01, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b1);
        wait_done32();
        issue32(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 1'b1);
        wait_done32();
        issue32(2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 1'b1);
        wait_done32();
        issue32(2'b01, 32'h80000000, 32'd1, 32'hFFFFFFFF, 32'h80000000, 1'b1);
        wait_done32();

        // MADD / MSUB on a preloaded HI:LO
        b32.wr_hi = 1'b1; b32.wr_data = 32'h1;
        @(negedge clk);
        b32.wr_hi = 1'b0; b32.wr_lo = 1'b1; b32.wr_data = 32'hFFFFFFFF;
        @(negedge clk);
        b32.wr_lo = 1'b0;
        chk("w32_pre_hi", b32.productHI, 32'h1);
        chk("w32_pre_lo", b32.productLO, 32'hFFFFFFFF);
        issue32(2'b10, 32'd1, 32'd1, 32'h2, 32'h0, 1'b1);
        wait_done32();
        issue32(2'b11, 32'hFFFFFFFE, 32'd3, 32'h2, 32'h6, 1'b1);
        wait_done32();

        // Start/write/operand noise while busy must not disturb the op
        issue32(2'b01, 32'h12345, 32'h100, 32'h0, 32'h01234500, 1'b1);
        for (int i = 0; i < 30; i++) begin
            b32.op           = 2'($urandom_range(0, 3));
            b32.multiplicand = (i == 5) ? 32'd4 : $urandom;
            b32.multiplier   = (i == 5) ? 32'd4 : $urandom;
            b32.start        = (i == 5);
            b32.wr_hi        = (i == 10);
            b32.wr_lo        = (i == 12);
            b32.wr_data      = 32'hDEAD;
            if (i == 20) begin
                chk("w32_hold_hi", b32.productHI, 32'h2);
                chk("w32_hold_lo", b32.productLO, 32'h6);
            end
            @(negedge clk);
        end
        b32.start = 1'b0; b32.wr_hi = 1'b0; b32.wr_lo = 1'b0;
        wait_done32();
        // Back-to-back: start on the done cycle
        issue32(2'b00, 32'd3, 32'd5, 32'h0, 32'd15, 1'b1);
        wait_done32();
        repeat (40) @(negedge clk);
    endtask

    task automatic run8();
        rst_n8 = 1'b0;
        repeat (2) @(negedge clk);
        chk("w8_rst_busy", {31'h0, b8.busy}, 32'h0);
        chk("w8_rst_hi", {24'h0, b8.productHI}, 32'h0);
        rst_n8 = 1'b1;
        @(negedge clk);
        issue8(2'b01, 8'h80, 8'h7F, 8'hC0, 8'h80);
        wait_done8();
        issue8(2'b00, 8'hFF, 8'hFF, 8'hFE, 8'h01);
        wait_done8();
        repeat (20) @(negedge clk);
    endtask

    initial begin
        b32.start = 1'b0; b32.op = 2'b00; b32.multiplicand = '0; b32.multiplier = '0;
        b32.wr_hi = 1'b0; b32.wr_lo = 1'b0; b32.wr_data = '0;
        b8.start = 1'b0; b8.op = 2'b00; b8.multiplicand = '0; b8.multiplier = '0;
        b8.wr_hi = 1'b0; b8.wr_lo = 1'b0; b8.wr_data = '0;
        rst_n32 = 1'b0;
        rst_n8  = 1'b0;
        fork
            run32();
            run8();
        join
        chk("w32_queue_empty", 32'(q32.size()), 32'h0);
        chk("w8_queue_empty", 32'(q8.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seq_mult_acc.md
Name: seq_mult_acc

Overview:
- Parametrised, iterative shift-add multiplier with internal HI/LO result registers for the CPU datapath.
- Supports unsigned and signed multiply, plus signed multiply-accumulate and multiply-subtract into HI:LO.
- Uses a start/busy/done handshake in place of a combinational array.
- Supports direct HI/LO writes for move-to-HI/LO instructions.

Parameters:
- WIDTH, 32: operand width. HI and LO are each WIDTH bits; the full product is 2*WIDTH bits. Minimum is 4.
- CNT_W, 6: width of the iteration counter. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  request an operation. Sampled only in IDLE.
- op  in  2  operation select, captured with start: 00 MULTU, 01 MULT (signed), 10 MADD (HI:LO += signed product), 11 MSUB (HI:LO -= signed product).
- multiplicand  in  WIDTH  operand A, captured with start.
- multiplier  in  WIDTH  operand B, captured with start.
- wr_hi  in  1  write wr_data into HI. Honoured only in IDLE.
- wr_lo  in  1  write wr_data into LO. Honoured only in IDLE.
- wr_data  in  WIDTH  data for HI/LO writes.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse; HI/LO hold the new result in the same cycle.
- productHI  out  WIDTH  HI register, which is the upper half of the product.
- productLO  out  WIDTH  LO register, which is the lower half of the product.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; busy=0, done=0; productHI=0, productLO=0.
  - Counter and internal operand registers are cleared.
  - Takes effect immediately, including mid-operation; the in-flight operation is discarded and no done is produced.
- States: IDLE, LOAD, ITER, FIX.
- IDLE:
  - start=1 at edge N: capture op and both operands; busy=1; go to LOAD.
  - wr_hi/wr_lo on the same edge as start are ignored; start has priority.
  - No start: wr_hi=1 writes productHI, wr_lo=1 writes productLO. Both may be set together.
- LOAD (edge N+1):
  - For op != 00, record neg = A[W-1] XOR B[W-1], and replace each negative operand with its two's-complement magnitude as a WIDTH-bit unsigned value.
  - The most negative value maps to 2^(W-1), which is representable.
  - For op = 00, neg=0 and operands are used as-is.
  - Clear the 2W-bit partial product; counter=0; go to ITER.
- ITER (edges N+2 .. N+W+1, exactly WIDTH cycles):
  - Each cycle, if B[counter]=1, add A to partial[2W-1:W] with a (W+1)-bit sum so the carry is kept.
  - Then shift the partial product right by 1, with the carry entering bit 2W-1.
  - counter increments; after the iteration with counter=W-1, go to FIX.
- FIX (edge N+W+2):
  - p = neg ? -partial : partial, in 2W-bit two's complement.
  - MULTU/MULT: {HI,LO} = p.
  - MADD: {HI,LO} = {HI,LO} + p, modulo 2^(2W).
  - MSUB: {HI,LO} = {HI,LO} - p, modulo 2^(2W).
  - On this edge: busy->0, done->1 for exactly one cycle, state->IDLE.
- Latency: WIDTH+2 clock edges from the start edge to the result edge (34 for WIDTH=32).
- Back-to-back operation: a new start may be accepted on the cycle done is high, because the state is already IDLE.
- start while busy is ignored; it is neither queued nor able to corrupt captured operands.
- Operand inputs may change after the start edge without affecting the result.
- wr_hi/wr_lo while busy are ignored; HI/LO change only in FIX or on an IDLE write.
- productHI/productLO hold their values between operations and during ITER.
- There are no X-propagating paths: all registers are reset, and no combinational output depends on op/operand inputs.

Test Plan:
- Reset mid-operation:
  - Stimulus: MULT 7*9; assert reset_n=0 at edge N+10; release; then start MULTU 2*3.
  - Required: busy=0, HI/LO=0 immediately on reset, no done pulse; the new operation gives LO=6, HI=0 with done at its start edge+34.
- MULTU:
  - Stimulus: 0xFFFFFFFF*0xFFFFFFFF.
  - Required: done exactly 34 edges after start; HI=0xFFFFFFFE, LO=0x00000001.
  - Stimulus: 0*0x12345678.
  - Required: HI=LO=0.
- MULT signed:
  - Stimulus: -3*5.
  - Required: HI=0xFFFFFFFF, LO=0xFFFFFFF1.
  - Stimulus: -1*-1.
  - Required: HI=0, LO=1.
  - Stimulus: 0x80000000*0x80000000.
  - Required: HI=0x40000000, LO=0.
  - Stimulus: 0x80000000*1.
  - Required: HI=0xFFFFFFFF, LO=0x80000000.
- MADD/MSUB:
  - Stimulus: wr_hi with 0x00000001, wr_lo with 0xFFFFFFFF (HI:LO=0x1_FFFFFFFF), then MADD 1*1.
  - Required: HI=2, LO=0.
  - Stimulus: then MSUB -2*3.
  - Required: HI=2, LO=6.
- Handshake/ignore rules:
  - Stimulus: during busy, pulse start with 4*4 and assert wr_hi with 0xDEAD; change operand inputs every cycle.
  - Required: the first operation's result is unaffected and only one done pulse occurs.
  - Stimulus: a new start on the done cycle.
  - Required: accepted, with its own done 34 edges later.
- Parametric:
  - Stimulus: WIDTH=8, CNT_W=4, MULT 0x80*0x7F.
  - Required: done after 10 edges; HI=0xC0, LO=0x80.
  - Stimulus: MULTU 0xFF*0xFF.
  - Required: HI=0xFE, LO=0x01.
